// File: rtl/tp_stage_seq.sv
// Time-pulse sequencer: one-hot T rotation per memory cycle, stage staging at the
// MCT boundary, single-step hold, and GOJAM restart handling.
module tp_stage_seq #(
    parameter int NTP     = 12,
    parameter int STAGE_W = 2,
    parameter int MCT_W   = 16
) (
    input  logic               CLOCK,
    input  logic               rst,
    input  logic               GOJAM,
    input  logic               STALL,
    input  logic               STG_LD,
    input  logic [STAGE_W-1:0] STG_SET,
    input  logic               STG_CLR,
    input  logic               SSTEP,
    input  logic               STEP,
    output logic [NTP-1:0]     T,
    output logic [NTP-1:0]     T_,
    output logic [STAGE_W-1:0] STAGE,
    output logic               MCT_END,
    output logic               GOJ1,
    output logic               HALTED,
    output logic [MCT_W-1:0]   MCT_COUNT
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [NTP-1:0] T01 = {{(NTP-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [NTP-1:0]       t_q, t_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [STAGE_W-1:0]   pend_q, pend_d;
    logic [MCT_W-1:0]     cnt_q, cnt_d;
    logic                 goj1_q, goj1_d;
    logic                 step_prev_q;

    logic [STAGE_W-1:0]   pend_upd;
    logic                 step_edge;
    logic                 boundary;

    // Clear beats load; this value also feeds STAGE directly at the boundary.
    assign pend_upd  = STG_CLR ? '0 : (STG_LD ? STG_SET : pend_q);
    assign step_edge = STEP & ~step_prev_q;
    assign boundary  = t_q[NTP-1];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        stage_d = stage_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        goj1_d  = goj1_q;
        if (GOJAM) begin
            state_d = RUN;
            t_d     = T01;
            stage_d = '0;
            pend_d  = '0;
            goj1_d  = 1'b1;
        end else if (!STALL) begin
            case (state_q)
                RUN: begin
                    pend_d = pend_upd;
                    t_d    = {t_q[NTP-2:0], t_q[NTP-1]};
                    if (boundary) begin
                        stage_d = pend_upd;
                        pend_d  = '0;
                        cnt_d   = cnt_q + 1'b1;
                        goj1_d  = 1'b0;
                        if (SSTEP) begin
                            state_d = HOLD;
                            t_d     = '0;
                        end
                    end
                end
                HOLD: begin
                    pend_d = pend_upd;
                    // Only a fresh STEP edge or leaving single-step mode releases the hold.
                    if (step_edge || !SSTEP) begin
                        state_d = RUN;
                        t_d     = T01;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q     <= RUN;
            t_q         <= T01;
            stage_q     <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            goj1_q      <= 1'b1;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            stage_q     <= stage_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            goj1_q      <= goj1_d;
            step_prev_q <= STEP;
        end
    end

    // HALTED is the state register itself, so it doubles as the FSM debug view.
    assign T         = t_q;
    assign T_        = ~t_q;
    assign STAGE     = stage_q;
    assign MCT_END   = t_q[NTP-1];
    assign GOJ1      = goj1_q;
    assign HALTED    = (state_q == HOLD);
    assign MCT_COUNT = cnt_q;

endmodule

// File: tb/tb_tp_stage_seq.sv
// Directed bench for tp_stage_seq: default 12-pulse instance plus a 4-pulse
// instance for the short-period and counter-wrap case.
module tb_tp_stage_seq;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b1, GOJAM = 1'b0, STALL = 1'b0, STG_LD = 1'b0, STG_CLR = 1'b0;
    logic [1:0]  STG_SET = 2'd0;
    logic        SSTEP = 1'b0, STEP = 1'b0;
    logic [11:0] T, T_;
    logic [1:0]  STAGE;
    logic        MCT_END, GOJ1, HALTED;
    logic [15:0] MCT_COUNT;

    logic        rst_b = 1'b1, zero_b = 1'b0;
    logic [2:0]  set_b = 3'd0;
    logic [3:0]  t_b, tn_b, cnt_b;
    logic [2:0]  stage_b;
    logic        mct_end_b, goj1_b, halted_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLOCK = ~CLOCK;

    tp_stage_seq dut (
        .CLOCK(CLOCK), .rst(rst), .GOJAM(GOJAM), .STALL(STALL), .STG_LD(STG_LD),
        .STG_SET(STG_SET), .STG_CLR(STG_CLR), .SSTEP(SSTEP), .STEP(STEP),
        .T(T), .T_(T_), .STAGE(STAGE), .MCT_END(MCT_END), .GOJ1(GOJ1),
        .HALTED(HALTED), .MCT_COUNT(MCT_COUNT)
    );

    tp_stage_seq #(.NTP(4), .STAGE_W(3), .MCT_W(4)) dut_b (
        .CLOCK(CLOCK), .rst(rst_b), .GOJAM(zero_b), .STALL(zero_b), .STG_LD(zero_b),
        .STG_SET(set_b), .STG_CLR(zero_b), .SSTEP(zero_b), .STEP(zero_b),
        .T(t_b), .T_(tn_b), .STAGE(stage_b), .MCT_END(mct_end_b), .GOJ1(goj1_b),
        .HALTED(halted_b), .MCT_COUNT(cnt_b)
    );

    task automatic clk(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic do_reset();
        GOJAM = 0; STALL = 0; STG_LD = 0; STG_CLR = 0; STG_SET = 0; SSTEP = 0; STEP = 0;
        rst = 1;
        clk();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; GOJAM = 1; STALL = 1; SSTEP = 1; STG_LD = 1; STG_SET = 2'd3;
        clk();
        n_checks++;
        if (T !== 12'h001 || T_ !== 12'hffe || STAGE !== 2'd0 || MCT_END !== 1'b0 ||
            GOJ1 !== 1'b1 || HALTED !== 1'b0 || MCT_COUNT !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_values: T=%h T_=%h STAGE=%0d END=%b GOJ1=%b HALT=%b CNT=%0d exp 001 ffe 0 0 1 0 0",
                     T, T_, STAGE, MCT_END, GOJ1, HALTED, MCT_COUNT);
        end
        // Mid-MCT reset with a pending load must leave no trace.
        do_reset();
        clk(3);
        STG_LD = 1; STG_SET = 2'd2;
        clk();
        STG_LD = 0;
        clk(2);
        rst = 1;
        clk();
        rst = 0;
        n_checks++;
        if (T !== 12'h001 || MCT_COUNT !== 16'd0 || GOJ1 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_mct: T=%h CNT=%0d GOJ1=%b exp 001 0 1", T, MCT_COUNT, GOJ1);
        end
        clk(12);
        n_checks++;
        if (STAGE !== 2'd0 || MCT_COUNT !== 16'd1) begin
            n_errors++;
            $display("FAIL reset_pending_dropped: STAGE=%0d CNT=%0d exp 0 1", STAGE, MCT_COUNT);
        end
    endtask

    task automatic test_free_run();
        logic [11:0] exp_t;
        int ends;
        ends = 0;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            clk();
            exp_t = 12'h001 << (i % 12);
            if (MCT_END) ends++;
            n_checks++;
            if (T !== exp_t || T_ !== ~exp_t) begin
                n_errors++;
                $display("FAIL free_run_t clk %0d: T=%h T_=%h exp %h", i, T, T_, exp_t);
            end
            if (i == 11) begin
                n_checks++;
                if (GOJ1 !== 1'b1 || MCT_COUNT !== 16'd0) begin
                    n_errors++;
                    $display("FAIL goj1_before_boundary: GOJ1=%b CNT=%0d exp 1 0", GOJ1, MCT_COUNT);
                end
            end
            if (i == 12) begin
                n_checks++;
                if (GOJ1 !== 1'b0 || MCT_COUNT !== 16'd1) begin
                    n_errors++;
                    $display("FAIL goj1_clear: GOJ1=%b CNT=%0d exp 0 1", GOJ1, MCT_COUNT);
                end
            end
            if (i == 24) begin
                n_checks++;
                if (MCT_COUNT !== 16'd2) begin
                    n_errors++;
                    $display("FAIL count_24: CNT=%0d exp 2", MCT_COUNT);
                end
            end
        end
        n_checks++;
        if (ends != 2) begin
            n_errors++;
            $display("FAIL mct_end_hits: got %0d exp 2", ends);
        end
    endtask

    task automatic test_stage();
        do_reset();
        clk(4);
        n_checks++;
        if (T !== 12'h010) begin
            n_errors++;
            $display("FAIL stage_at_t05: T=%h exp 010", T);
        end
        STG_LD = 1; STG_SET = 2'd2;
        clk();
        STG_LD = 0;
        n_checks++;
        if (STAGE !== 2'd0) begin
            n_errors++;
            $display("FAIL stage_mid_mct: STAGE=%0d exp 0", STAGE);
        end
        clk(2);
        STG_CLR = 1;
        clk();
        STG_CLR = 0;
        clk(4);
        n_checks++;
        if (T !== 12'h001 || STAGE !== 2'd0 || MCT_COUNT !== 16'd1) begin
            n_errors++;
            $display("FAIL stage_cleared: T=%h STAGE=%0d CNT=%0d exp 001 0 1", T, STAGE, MCT_COUNT);
        end
        clk(4);
        STG_LD = 1; STG_SET = 2'd2;
        clk();
        STG_LD = 0;
        clk(7);
        n_checks++;
        if (T !== 12'h001 || STAGE !== 2'd2) begin
            n_errors++;
            $display("FAIL stage_loaded: T=%h STAGE=%0d exp 001 2", T, STAGE);
        end
        clk(11);
        n_checks++;
        if (STAGE !== 2'd2 || T !== 12'h800) begin
            n_errors++;
            $display("FAIL stage_held: T=%h STAGE=%0d exp 800 2", T, STAGE);
        end
        // Load on the boundary cycle itself goes straight to STAGE.
        STG_LD = 1; STG_SET = 2'd1;
        clk();
        STG_LD = 0;
        n_checks++;
        if (STAGE !== 2'd1) begin
            n_errors++;
            $display("FAIL stage_boundary_load: STAGE=%0d exp 1", STAGE);
        end
        clk(5);
        STG_LD = 1; STG_CLR = 1; STG_SET = 2'd3;
        clk();
        STG_LD = 0; STG_CLR = 0;
        clk(6);
        n_checks++;
        if (STAGE !== 2'd0 || T !== 12'h001) begin
            n_errors++;
            $display("FAIL stage_clr_wins: T=%h STAGE=%0d exp 001 0", T, STAGE);
        end
    endtask

    task automatic test_stall();
        do_reset();
        clk(5);
        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            clk();
            n_checks++;
            if (T !== 12'h020) begin
                n_errors++;
                $display("FAIL stall_hold %0d: T=%h exp 020", i, T);
            end
        end
        STALL = 0;
        clk();
        n_checks++;
        if (T !== 12'h040) begin
            n_errors++;
            $display("FAIL stall_resume: T=%h exp 040", T);
        end
        clk(5);
        n_checks++;
        if (MCT_COUNT !== 16'd0 || MCT_END !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_delay: CNT=%0d END=%b exp 0 1", MCT_COUNT, MCT_END);
        end
        clk();
        n_checks++;
        if (MCT_COUNT !== 16'd1 || T !== 12'h001) begin
            n_errors++;
            $display("FAIL stall_boundary: CNT=%0d T=%h exp 1 001", MCT_COUNT, T);
        end
    endtask

    task automatic test_sstep();
        do_reset();
        SSTEP = 1;
        clk(12);
        n_checks++;
        if (T !== 12'h000 || HALTED !== 1'b1 || MCT_COUNT !== 16'd1 || MCT_END !== 1'b0) begin
            n_errors++;
            $display("FAIL sstep_halt: T=%h HALT=%b CNT=%0d END=%b exp 000 1 1 0", T, HALTED, MCT_COUNT, MCT_END);
        end
        clk(3);
        n_checks++;
        if (T !== 12'h000 || HALTED !== 1'b1) begin
            n_errors++;
            $display("FAIL sstep_stay: T=%h HALT=%b exp 000 1", T, HALTED);
        end
        STEP = 1;
        clk();
        n_checks++;
        if (T !== 12'h001 || HALTED !== 1'b0) begin
            n_errors++;
            $display("FAIL step_release: T=%h HALT=%b exp 001 0", T, HALTED);
        end
        clk(4);
        STEP = 0;
        clk(3);
        STEP = 1;
        clk(4);
        n_checks++;
        if (T !== 12'h800 || HALTED !== 1'b0) begin
            n_errors++;
            $display("FAIL step_one_mct: T=%h HALT=%b exp 800 0", T, HALTED);
        end
        clk();
        n_checks++;
        if (T !== 12'h000 || HALTED !== 1'b1 || MCT_COUNT !== 16'd2) begin
            n_errors++;
            $display("FAIL step_rehalt: T=%h HALT=%b CNT=%0d exp 000 1 2", T, HALTED, MCT_COUNT);
        end
        clk(2);
        n_checks++;
        if (HALTED !== 1'b1) begin
            n_errors++;
            $display("FAIL step_not_queued: HALT=%b exp 1", HALTED);
        end
        SSTEP = 0; STEP = 0;
        clk();
        n_checks++;
        if (T !== 12'h001 || HALTED !== 1'b0) begin
            n_errors++;
            $display("FAIL sstep_drop: T=%h HALT=%b exp 001 0", T, HALTED);
        end
    endtask

    task automatic test_gojam();
        do_reset();
        SSTEP = 1;
        clk(2);
        STG_LD = 1; STG_SET = 2'd3;
        clk();
        STG_LD = 0;
        clk(9);
        n_checks++;
        if (STAGE !== 2'd3 || HALTED !== 1'b1 || MCT_COUNT !== 16'd1) begin
            n_errors++;
            $display("FAIL gojam_setup: STAGE=%0d HALT=%b CNT=%0d exp 3 1 1", STAGE, HALTED, MCT_COUNT);
        end
        STG_LD = 1; STG_SET = 2'd3;
        clk();
        STG_LD = 0;
        GOJAM = 1; STALL = 1;
        clk();
        n_checks++;
        if (T !== 12'h001 || STAGE !== 2'd0 || HALTED !== 1'b0 || GOJ1 !== 1'b1 || MCT_COUNT !== 16'd1) begin
            n_errors++;
            $display("FAIL gojam_apply: T=%h STAGE=%0d HALT=%b GOJ1=%b CNT=%0d exp 001 0 0 1 1",
                     T, STAGE, HALTED, GOJ1, MCT_COUNT);
        end
        clk();
        n_checks++;
        if (T !== 12'h001) begin
            n_errors++;
            $display("FAIL gojam_held: T=%h exp 001", T);
        end
        GOJAM = 0; STALL = 0; SSTEP = 0;
        clk(11);
        n_checks++;
        if (GOJ1 !== 1'b1 || T !== 12'h800) begin
            n_errors++;
            $display("FAIL goj1_window: GOJ1=%b T=%h exp 1 800", GOJ1, T);
        end
        clk();
        n_checks++;
        if (GOJ1 !== 1'b0 || STAGE !== 2'd0 || MCT_COUNT !== 16'd2) begin
            n_errors++;
            $display("FAIL gojam_after: GOJ1=%b STAGE=%0d CNT=%0d exp 0 0 2", GOJ1, STAGE, MCT_COUNT);
        end
    endtask

    task automatic test_small_ntp();
        logic [3:0] exp_t, exp_c;
        rst_b = 1;
        clk();
        rst_b = 0;
        for (int i = 1; i <= 70; i++) begin
            clk();
            exp_t = 4'h1 << (i % 4);
            exp_c = 4'((i / 4) % 16);
            n_checks++;
            if (t_b !== exp_t || tn_b !== ~exp_t || cnt_b !== exp_c) begin
                n_errors++;
                $display("FAIL ntp4 clk %0d: T=%h T_=%h CNT=%0d exp %h %h %0d", i, t_b, tn_b, cnt_b, exp_t, ~exp_t, exp_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stage();
        test_stall();
        test_sstep();
        test_gojam();
        test_small_ntp();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
